// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types, default widths and checksum fold for the instruction-memory loader
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Folds one instruction word into a running XOR checksum.
    function automatic logic [DATA_W_DEF-1:0] xor_fold(
        input logic [DATA_W_DEF-1:0] acc,
        input logic [DATA_W_DEF-1:0] word
    );
        return acc ^ word;
    endfunction

endpackage

// File: rtl/imem_loader_checksum.sv
// rtl/imem_loader_checksum.sv - XOR checksum accumulator with synchronous clear and enable
module imem_loader_checksum
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    // Clear wins over accumulate so a new load starts from a clean checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= xor_fold(sum, data);
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - host-to-imem program uploader gating the fetch stage; readback verify under IMEM_LOADER_READBACK_EN
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = 256,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              run_req,
    input  logic              halt,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic [ADDR_W-1:0] instmem_export_address,
    output logic [DATA_W-1:0] instmem_export_data,
    output logic              instmem_export_MW,
    output logic              instmem_export_MR,
    input  logic [DATA_W-1:0] instmem_export_out,
    output logic              cpu_enable,
    output logic              busy,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow,
    output logic              err_verify
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic              term_seen, term_seen_n;
    logic              term_last, term_last_n;
    logic              host_ready_n;
    logic              mw_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [ADDR_W:0]   word_count_n;
    logic              err_overflow_n;

`ifdef IMEM_LOADER_READBACK_EN
    logic              mr_n, mr_q, err_verify_n;
    logic              sum_clear, load_en, rb_en;
    logic [ADDR_W:0]   rd_issued, rd_issued_n;
    logic [DATA_W-1:0] load_sum, rb_sum;

    imem_loader_checksum #(.DATA_W(DATA_W)) u_load_sum (
        .clk(clk), .reset(reset), .clear(sum_clear), .en(load_en),
        .data(host_data), .sum(load_sum)
    );

    imem_loader_checksum #(.DATA_W(DATA_W)) u_rb_sum (
        .clk(clk), .reset(reset), .clear(sum_clear), .en(rb_en),
        .data(instmem_export_out), .sum(rb_sum)
    );
`else
    logic unused_readback;
    assign unused_readback   = ^instmem_export_out;
    assign instmem_export_MR = 1'b0;
    assign err_verify        = 1'b0;
`endif

    // Next-state and next-output decode; the terminating write lands in LOAD before leaving it.
    always_comb begin
        state_n        = state;
        wr_addr_n      = wr_addr;
        term_seen_n    = term_seen;
        term_last_n    = term_last;
        mw_n           = 1'b0;
        addr_n         = instmem_export_address;
        data_n         = instmem_export_data;
        word_count_n   = word_count;
        err_overflow_n = err_overflow;
`ifdef IMEM_LOADER_READBACK_EN
        mr_n         = 1'b0;
        err_verify_n = err_verify;
        rd_issued_n  = rd_issued;
        sum_clear    = 1'b0;
        load_en      = 1'b0;
        rb_en        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_n        = LOAD;
                    wr_addr_n      = BASE;
                    term_seen_n    = 1'b0;
                    term_last_n    = 1'b0;
                    word_count_n   = '0;
                    err_overflow_n = 1'b0;
`ifdef IMEM_LOADER_READBACK_EN
                    err_verify_n = 1'b0;
                    sum_clear    = 1'b1;
`endif
                end else if (run_req) begin
                    state_n = RUN;
                end
            end
            LOAD: begin
                if (term_seen) begin
                    if (term_last) begin
`ifdef IMEM_LOADER_READBACK_EN
                        state_n     = VERIFY;
                        rd_issued_n = '0;
`else
                        state_n = RUN;
`endif
                    end else begin
                        state_n        = IDLE;
                        err_overflow_n = 1'b1;
                    end
                end else if (host_valid && host_ready) begin
                    mw_n         = 1'b1;
                    addr_n       = wr_addr;
                    data_n       = host_data;
                    word_count_n = word_count + 1'b1;
`ifdef IMEM_LOADER_READBACK_EN
                    load_en = 1'b1;
`endif
                    if (host_last || wr_addr == LAST) begin
                        term_seen_n = 1'b1;
                        term_last_n = host_last;
                    end else begin
                        wr_addr_n = wr_addr + 1'b1;
                    end
                end
            end
            VERIFY: begin
`ifdef IMEM_LOADER_READBACK_EN
                // Read data trails MR by one cycle, so mr_q marks a word to fold in.
                rb_en = mr_q;
                if (rd_issued < word_count) begin
                    mr_n        = 1'b1;
                    addr_n      = BASE + rd_issued[ADDR_W-1:0];
                    rd_issued_n = rd_issued + 1'b1;
                end else if (!instmem_export_MR && !mr_q) begin
                    if (rb_sum == load_sum) begin
                        state_n = RUN;
                    end else begin
                        state_n      = IDLE;
                        err_verify_n = 1'b1;
                    end
                end
`else
                state_n = IDLE;
`endif
            end
            RUN: begin
                if (halt) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        host_ready_n = (state_n == LOAD) && !term_seen_n;
    end

    // State and registered outputs; every output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            wr_addr                <= '0;
            term_seen              <= 1'b0;
            term_last              <= 1'b0;
            host_ready             <= 1'b0;
            instmem_export_address <= '0;
            instmem_export_data    <= '0;
            instmem_export_MW      <= 1'b0;
            cpu_enable             <= 1'b0;
            busy                   <= 1'b0;
            word_count             <= '0;
            err_overflow           <= 1'b0;
`ifdef IMEM_LOADER_READBACK_EN
            instmem_export_MR <= 1'b0;
            mr_q              <= 1'b0;
            err_verify        <= 1'b0;
            rd_issued         <= '0;
`endif
        end else begin
            state                  <= state_n;
            wr_addr                <= wr_addr_n;
            term_seen              <= term_seen_n;
            term_last              <= term_last_n;
            host_ready             <= host_ready_n;
            instmem_export_address <= addr_n;
            instmem_export_data    <= data_n;
            instmem_export_MW      <= mw_n;
            cpu_enable             <= (state_n == RUN);
            busy                   <= (state_n == LOAD) || (state_n == VERIFY);
            word_count             <= word_count_n;
            err_overflow           <= err_overflow_n;
`ifdef IMEM_LOADER_READBACK_EN
            instmem_export_MR <= mr_n;
            mr_q              <= instmem_export_MR;
            err_verify        <= err_verify_n;
            rd_issued         <= rd_issued_n;
`endif
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - randomized self-checking bench for imem_program_loader
`timescale 1ns/1ps
module tb_imem_program_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int START  = 0;
`ifdef IMEM_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              run_req = 1'b0;
    logic              halt = 1'b0;
    logic              host_valid = 1'b0;
    logic [DATA_W-1:0] host_data = '0;
    logic              host_last = 1'b0;
    logic              host_ready;
    logic [ADDR_W-1:0] instmem_export_address;
    logic [DATA_W-1:0] instmem_export_data;
    logic              instmem_export_MW;
    logic              instmem_export_MR;
    logic [DATA_W-1:0] instmem_export_out;
    logic              cpu_enable;
    logic              busy;
    logic [ADDR_W:0]   word_count;
    logic              err_overflow;
    logic              err_verify;

    imem_program_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .START_ADDR(START)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .run_req(run_req), .halt(halt),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
        .host_ready(host_ready), .instmem_export_address(instmem_export_address),
        .instmem_export_data(instmem_export_data), .instmem_export_MW(instmem_export_MW),
        .instmem_export_MR(instmem_export_MR), .instmem_export_out(instmem_export_out),
        .cpu_enable(cpu_enable), .busy(busy), .word_count(word_count),
        .err_overflow(err_overflow), .err_verify(err_verify)
    );

    always #5 clk = ~clk;

    // Instruction memory with one-cycle read latency and optional corruption at address 2.
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] rd_q;
    bit                corrupt_on = 1'b0;
    always @(posedge clk) begin
        if (instmem_export_MW) mem[instmem_export_address] <= instmem_export_data;
        if (instmem_export_MR)
            rd_q <= mem[instmem_export_address] ^
                    ((corrupt_on && instmem_export_address == 8'd2) ? 32'h0000_0100 : 32'h0);
    end
    assign instmem_export_out = rd_q;

    int                n_checks = 0;
    int                n_fail = 0;
    bit                chk_en = 1'b0;
    bit                exp_ready = 1'b0;
    bit                exp_mw = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic [DATA_W-1:0] words [DEPTH];
    int                last_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_mw = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_host_ready"}, host_ready, 0);
        check({tag, "_address"}, instmem_export_address, 0);
        check({tag, "_data"}, instmem_export_data, 0);
        check({tag, "_mw"}, instmem_export_MW, 0);
        check({tag, "_mr"}, instmem_export_MR, 0);
        check({tag, "_cpu_enable"}, cpu_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_err_overflow"}, err_overflow, 0);
        check({tag, "_err_verify"}, err_verify, 0);
    endtask

    // Per-cycle comparison of the write port and handshake against the bench's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("host_ready", host_ready, exp_ready);
            check("mw", instmem_export_MW, exp_mw);
            if (exp_mw) begin
                check("wr_addr", instmem_export_address, exp_addr);
                check("wr_data", instmem_export_data, exp_data);
            end
            if (!RB) check("mr_tied", instmem_export_MR, 0);
            check("run_exclusive", cpu_enable & (instmem_export_MW | host_ready | busy), 0);
        end
    end

    task automatic upload(input int n, input bit with_last, input int gap_mode,
                          input bit corrupt, input bit also_run);
        bit exp_run;
        corrupt_on = corrupt;
        load_start = 1'b1;
        run_req = also_run;
        step();
        load_start = 1'b0;
        run_req = 1'b0;
        exp_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1 && i > 0) begin
                host_valid = 1'b0;
                step();
            end
            if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    host_valid = 1'b0;
                    step();
                end
            end
            host_valid = 1'b1;
            host_data = words[i];
            host_last = with_last && (i == n - 1);
            if (gap_mode == 2) begin
                halt = ($urandom_range(0, 3) == 0);
                run_req = ($urandom_range(0, 3) == 0);
            end
            step();
            halt = 1'b0;
            run_req = 1'b0;
            exp_mw = 1'b1;
            exp_addr = ADDR_W'(START + i);
            exp_data = words[i];
            if (host_last || (START + i) == DEPTH - 1) exp_ready = 1'b0;
        end
        host_last = 1'b0;
        host_data = $urandom();
        repeat (2) step();
        host_valid = 1'b0;
        for (int k = 0; k < 64 && busy; k++) step();
        check("settle_busy", busy, 0);
        exp_run = with_last && !(RB && corrupt);
        check("cpu_enable_after_load", cpu_enable, exp_run);
        check("word_count", word_count, 64'(n));
        check("err_overflow", err_overflow, !with_last);
        check("err_verify", err_verify, RB && corrupt);
        for (int i = 0; i < n; i++) check("mem_contents", mem[START + i], words[i]);
        last_n = n;
        if (exp_run) begin
            halt = 1'b1;
            step();
            halt = 1'b0;
            check("halt_cpu_off", cpu_enable, 0);
        end
        corrupt_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        chk_en = 1'b1;
        step();

        // Directed program from the bring-up sequence.
        words[0] = 32'h0000_0000;
        words[1] = 32'h8C08_0002;
        words[2] = 32'hAC08_0001;
        words[3] = 32'h0000_0000;
        upload(4, 1'b1, 0, 1'b0, 1'b0);
        check("t1_word_count", word_count, 4);
        check("t1_mem1", mem[1], 32'h8C08_0002);
        check("t1_mem2", mem[2], 32'hAC08_0001);

        // Gapped valid, with run_req colliding with load_start.
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
        upload(4, 1'b1, 1, 1'b0, 1'b1);

        // Full depth without last: overflow, CPU stays off.
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
        upload(DEPTH, 1'b0, 0, 1'b0, 1'b0);
        check("ovf_word_count", word_count, 8);
        check("ovf_flag", err_overflow, 1);
        check("ovf_cpu_off", cpu_enable, 0);

        // Full depth with last on the final address: no overflow.
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
        upload(DEPTH, 1'b1, 0, 1'b0, 1'b0);

        // run_req from IDLE; load_start during RUN is ignored; halt stops the CPU.
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("idle_halt_ignored", cpu_enable, 0);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("run_req_cpu_on", cpu_enable, 1);
        check("run_req_not_busy", busy, 0);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        repeat (2) step();
        check("run_load_ignored_cpu", cpu_enable, 1);
        check("run_load_ignored_wc", word_count, 64'(last_n));
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_next_cycle", cpu_enable, 0);

        // Reset in the middle of a load after two words.
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            host_valid = 1'b1;
            host_data = words[i];
            step();
            exp_mw = 1'b1;
            exp_addr = ADDR_W'(START + i);
            exp_data = words[i];
        end
        host_valid = 1'b0;
        #2;
        reset = 1'b1;
        exp_ready = 1'b0;
        exp_mw = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
        upload(3, 1'b1, 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_READBACK_EN
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
        upload(4, 1'b1, 0, 1'b1, 1'b0);
        check("verify_fail_cpu_off", cpu_enable, 0);
        upload(4, 1'b1, 0, 1'b0, 1'b0);
`endif

        // Randomized uploads with gaps and ignored halt/run_req noise.
        for (int t = 0; t < 20; t++) begin
            int  n;
            bit  wl;
            n = $urandom_range(1, DEPTH);
            wl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
            upload(n, wl, 2, 1'b0, 1'b0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
